// File: rtl/tensor_stream_deserializer.sv
// rtl/tensor_stream_deserializer.sv - valid/ready element stream to flat tensor bus assembler
// Fills m_vec LANES words per accepted beat, then holds it until the consumer takes it.
module tensor_stream_deserializer #(
  parameter int CH    = 1,
  parameter int H     = 1,
  parameter int W     = 1,
  parameter int WIDTH = 16,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CH*H*W*WIDTH-1:0] m_vec,
  output logic                   err_len,
  output logic                   busy
);
  localparam int N  = CH * H * W;
  localparam int IW = (N > 1) ? $clog2(N + 1) : 1;

  if ((N % LANES) != 0) begin : g_lanes_check
    $error("tensor_stream_deserializer: LANES must divide CH*H*W");
  end

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N*WIDTH-1:0]   vec_q, vec_d;
  logic                 s_ready_q, s_ready_d;
  logic                 m_valid_q, m_valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (s_valid && s_ready_q) begin
          for (int k = 0; k < LANES; k++) begin
            vec_d[(int'(idx_q) + k)*WIDTH +: WIDTH] = s_data[k*WIDTH +: WIDTH];
          end
          if (int'(idx_q) + LANES == N) begin
            // Length mismatch on the final beat is flagged but the tensor still goes out.
            state_d = HOLD;
            idx_d   = '0;
            err_d   = ~s_last;
          end else if (s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = IW'(int'(idx_q) + LANES);
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
    s_ready_d = (state_d == FILL);
    m_valid_d = (state_d == HOLD);
    busy_d    = (state_d == HOLD) || (idx_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      vec_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vec_q     <= vec_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_vec   = vec_q;
  assign err_len = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tensor_stream_deserializer.sv
// tb/tb_tensor_stream_deserializer.sv - directed bench for tensor_stream_deserializer
// Two instances: a_* with LANES=1 and b_* with LANES=2, both 2x2x2 tensors of 16-bit words.
module tb_tensor_stream_deserializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_s_valid = 0, a_s_ready, a_s_last = 0, a_m_valid, a_m_ready = 1, a_err_len, a_busy;
  logic [15:0]  a_s_data = '0;
  logic [127:0] a_m_vec;
  logic         b_s_valid = 0, b_s_ready, b_s_last = 0, b_m_valid, b_m_ready = 1, b_err_len, b_busy;
  logic [31:0]  b_s_data = '0;
  logic [127:0] b_m_vec;

  tensor_stream_deserializer #(.CH(2), .H(2), .W(2), .WIDTH(16), .LANES(1)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_last(a_s_last), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_vec(a_m_vec),
    .err_len(a_err_len), .busy(a_busy));

  tensor_stream_deserializer #(.CH(2), .H(2), .W(2), .WIDTH(16), .LANES(2)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_last(b_s_last), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_vec(b_m_vec),
    .err_len(b_err_len), .busy(b_busy));

  int tests = 0;
  int fails = 0;
  int a_err_cnt = 0, a_mv_cnt = 0, b_err_cnt = 0, b_mv_cnt = 0;

  always @(negedge clk) begin
    if (a_err_len) a_err_cnt++;
    if (a_m_valid) a_mv_cnt++;
    if (b_err_len) b_err_cnt++;
    if (b_m_valid) b_mv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] seq_vec(input int base);
    logic [127:0] v;
    for (int e = 0; e < 8; e++) v[e*16 +: 16] = 16'(base + e);
    return v;
  endfunction

  task automatic send_a(input logic [15:0] d, input logic last);
    logic acc;
    int   n;
    a_s_valid = 1; a_s_data = d; a_s_last = last;
    n = 0;
    acc = 0;
    while (!acc && n < 20) begin
      acc = a_s_ready;
      tick();
      n++;
    end
    a_s_valid = 0; a_s_last = 0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_a_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_b(input logic [31:0] d, input logic last);
    logic acc;
    int   n;
    b_s_valid = 1; b_s_data = d; b_s_last = last;
    n = 0;
    acc = 0;
    while (!acc && n < 20) begin
      acc = b_s_ready;
      tick();
      n++;
    end
    b_s_valid = 0; b_s_last = 0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_b_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic stream_a(input int base);
    for (int e = 0; e < 8; e++) send_a(16'(base + e), e == 7);
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    tests++;
    if (a_s_ready !== 1'b0 || a_m_valid !== 1'b0 || a_busy !== 1'b0 || a_err_len !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: s_ready=%b m_valid=%b busy=%b err=%b, required 0000",
               a_s_ready, a_m_valid, a_busy, a_err_len);
    end
    tests++;
    if (a_m_vec !== 128'd0 || b_m_vec !== 128'd0) begin
      fails++;
      $display("FAIL reset_vec: a=%h b=%h, required 0", a_m_vec, b_m_vec);
    end
    rst = 0;
    tick();
    tests++;
    if (a_s_ready !== 1'b1 || b_s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: s_ready a=%b b=%b, required 1", a_s_ready, b_s_ready);
    end
  endtask

  task automatic test_basic();
    int e0, m0;
    e0 = a_err_cnt; m0 = a_mv_cnt;
    a_m_ready = 1;
    stream_a(0);
    tests++;
    if (a_m_valid !== 1'b1 || a_s_ready !== 1'b0 || a_busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_hold: m_valid=%b s_ready=%b busy=%b, required 1 0 1", a_m_valid, a_s_ready, a_busy);
    end
    tests++;
    if (a_m_vec !== seq_vec(0)) begin
      fails++;
      $display("FAIL basic_vec: got %h, required %h", a_m_vec, seq_vec(0));
    end
    tick();
    tests++;
    if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_release: m_valid=%b s_ready=%b busy=%b, required 0 1 0", a_m_valid, a_s_ready, a_busy);
    end
    tests++;
    if (a_mv_cnt - m0 != 1 || a_err_cnt - e0 != 0) begin
      fails++;
      $display("FAIL basic_counts: m_valid cycles=%0d err cycles=%0d, required 1 0", a_mv_cnt - m0, a_err_cnt - e0);
    end
  endtask

  task automatic test_hold();
    a_m_ready = 0;
    stream_a(16);
    a_s_valid = 1; a_s_data = 16'hDEAD; a_s_last = 1;
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (a_s_ready !== 1'b0 || a_m_valid !== 1'b1 || a_m_vec !== seq_vec(16)) begin
        fails++;
        $display("FAIL hold_stable[%0d]: s_ready=%b m_valid=%b vec=%h, required 0 1 %h",
                 c, a_s_ready, a_m_valid, a_m_vec, seq_vec(16));
      end
      tick();
    end
    a_s_valid = 0; a_s_last = 0;
    a_m_ready = 1;
    tick();
    tests++;
    if (a_m_valid !== 1'b0 || a_s_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: m_valid=%b s_ready=%b, required 0 1", a_m_valid, a_s_ready);
    end
    stream_a(100);
    tests++;
    if (a_m_valid !== 1'b1 || a_m_vec !== seq_vec(100)) begin
      fails++;
      $display("FAIL hold_next: m_valid=%b vec=%h, required 1 %h", a_m_valid, a_m_vec, seq_vec(100));
    end
    tick();
  endtask

  task automatic test_lanes2();
    b_m_ready = 1;
    for (int i = 0; i < 4; i++) send_b({16'(2*i + 1), 16'(2*i)}, i == 3);
    tests++;
    if (b_m_valid !== 1'b1 || b_m_vec !== seq_vec(0)) begin
      fails++;
      $display("FAIL lanes2_vec: m_valid=%b vec=%h, required 1 %h", b_m_valid, b_m_vec, seq_vec(0));
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      send_b({16'(64 + 2*i + 1), 16'(64 + 2*i)}, i == 3);
    end
    tests++;
    if (b_m_valid !== 1'b1 || b_m_vec !== seq_vec(64)) begin
      fails++;
      $display("FAIL lanes2_gaps: m_valid=%b vec=%h, required 1 %h", b_m_valid, b_m_vec, seq_vec(64));
    end
    tick();
  endtask

  task automatic test_early_last();
    int e0, m0;
    e0 = a_err_cnt; m0 = a_mv_cnt;
    for (int e = 0; e < 4; e++) send_a(16'(50 + e), e == 3);
    tick(); tick();
    tests++;
    if (a_err_cnt - e0 != 1 || a_mv_cnt - m0 != 0 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL early_last: err cycles=%0d m_valid cycles=%0d busy=%b, required 1 0 0",
               a_err_cnt - e0, a_mv_cnt - m0, a_busy);
    end
    e0 = a_err_cnt;
    stream_a(200);
    tests++;
    if (a_m_valid !== 1'b1 || a_m_vec !== seq_vec(200)) begin
      fails++;
      $display("FAIL early_last_next: m_valid=%b vec=%h, required 1 %h", a_m_valid, a_m_vec, seq_vec(200));
    end
    tick();
    tests++;
    if (a_err_cnt - e0 != 0) begin
      fails++;
      $display("FAIL early_last_clean_err: err cycles=%0d, required 0", a_err_cnt - e0);
    end
  endtask

  task automatic test_final_no_last();
    logic [15:0]  vals [8];
    logic [127:0] exp;
    int e0;
    vals = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001, 16'h8001, 16'hFFFE, 16'h0000, 16'h1234};
    for (int e = 0; e < 8; e++) exp[e*16 +: 16] = vals[e];
    e0 = a_err_cnt;
    for (int e = 0; e < 8; e++) send_a(vals[e], 1'b0);
    tests++;
    if (a_m_valid !== 1'b1 || a_m_vec !== exp) begin
      fails++;
      $display("FAIL no_last_vec: m_valid=%b vec=%h, required 1 %h", a_m_valid, a_m_vec, exp);
    end
    tick(); tick();
    tests++;
    if (a_err_cnt - e0 != 1) begin
      fails++;
      $display("FAIL no_last_err: err cycles=%0d, required 1", a_err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = a_err_cnt;
    for (int e = 0; e < 5; e++) send_a(16'(e + 300), 1'b0);
    rst = 1;
    tick();
    rst = 0;
    tests++;
    if (a_m_valid !== 1'b0 || a_busy !== 1'b0 || a_m_vec !== 128'd0) begin
      fails++;
      $display("FAIL rst_fill: m_valid=%b busy=%b vec=%h, required 0 0 0", a_m_valid, a_busy, a_m_vec);
    end
    stream_a(400);
    tests++;
    if (a_m_valid !== 1'b1 || a_m_vec !== seq_vec(400)) begin
      fails++;
      $display("FAIL rst_fill_next: m_valid=%b vec=%h, required 1 %h", a_m_valid, a_m_vec, seq_vec(400));
    end
    tick();
    a_m_ready = 0;
    stream_a(500);
    tick();
    rst = 1;
    tick();
    rst = 0;
    a_m_ready = 1;
    tests++;
    if (a_m_valid !== 1'b0 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_hold: m_valid=%b busy=%b, required 0 0", a_m_valid, a_busy);
    end
    stream_a(600);
    tests++;
    if (a_m_valid !== 1'b1 || a_m_vec !== seq_vec(600)) begin
      fails++;
      $display("FAIL rst_hold_next: m_valid=%b vec=%h, required 1 %h", a_m_valid, a_m_vec, seq_vec(600));
    end
    tick();
    tests++;
    if (a_err_cnt - e0 != 0) begin
      fails++;
      $display("FAIL rst_err: err cycles=%0d, required 0", a_err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_lanes2();
    test_early_last();
    test_final_no_last();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
